// File: rtl/wb_ram_512x64_bridge.sv
// Wishbone classic slave in front of a 512x64 single-port RAM.
// Converts 32-bit bus reads/writes into one-cycle RAM strobes.
// For a read, the addressed 32-bit half of the 64-bit word is returned.
module wb_ram_512x64_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ram_en_o,
  output logic [7:0]  ram_we_o,
  output logic [8:0]  ram_a_o,
  output logic [63:0] ram_di_o,
  input  logic [63:0] ram_do_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;

  // The counter starts at READ_LATENCY-1 when WAIT is entered.
  // Data is sampled in the WAIT cycle where the counter reads 0.
  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        half_q, half_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        en_q, en_d;
  logic [7:0]  rwe_q, rwe_d;
  logic [8:0]  a_q, a_d;
  logic [63:0] di_q, di_d;
  logic [31:0] dat_q, dat_d;
  logic        hit;

  // Byte-lane address bits are not used; sub-word access goes through the byte selects.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);

  // Next-state, RAM strobe and read-capture decode.
  // Every output is produced one edge ahead so that it is driven directly from a flop.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    en_d    = 1'b0;
    rwe_d   = 8'h00;
    a_d     = a_q;
    di_d    = di_q;
    dat_d   = dat_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = REQ;
          we_d    = wbs_we_i;
          half_d  = wbs_adr_i[2];
          en_d    = 1'b1;
          a_d     = wbs_adr_i[11:3];
          di_d    = {wbs_dat_i, wbs_dat_i};
          if (wbs_we_i) begin
            rwe_d = wbs_adr_i[2] ? {wbs_sel_i, 4'b0000} : {4'b0000, wbs_sel_i};
          end
        end
      end
      REQ: begin
        // The strobe has already been issued in this cycle.
        // An abort therefore cannot undo a write.
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (we_q) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd0) begin
          dat_d   = half_q ? ram_do_i[63:32] : ram_do_i[31:0];
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      half_q  <= 1'b0;
      cnt_q   <= 2'd0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      rwe_q   <= 8'h00;
      a_q     <= 9'd0;
      di_q    <= 64'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      rwe_q   <= rwe_d;
      a_q     <= a_d;
      di_q    <= di_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ram_en_o  = en_q;
  assign ram_we_o  = rwe_q;
  assign ram_a_o   = a_q;
  assign ram_di_o  = di_q;

endmodule

// File: tb/tb_wb_ram_512x64_bridge.sv
// Bench for wb_ram_512x64_bridge: three instances with READ_LATENCY 1/2/3.
// Each instance sits in its own address window and has its own RAM model.
module tb_wb_ram_512x64_bridge;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i;

  logic        ack_w  [3];
  logic [31:0] dat_w  [3];
  logic        en_w   [3];
  logic [7:0]  rwe_w  [3];
  logic [8:0]  a_w    [3];
  logic [63:0] di_w   [3];
  logic [63:0] do_w   [3];

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  typedef struct {
    int          g;
    logic [8:0]  a;
    logic [7:0]  we;
    logic [63:0] di;
    int          t;
  } strobe_t;

  typedef struct {
    int          g;
    int          lat;
    logic [31:0] dat;
    int          t;
  } ackexp_t;

  strobe_t sq[$];
  ackexp_t aq[$];
  strobe_t s_m;
  ackexp_t k_m;

  function automatic logic [31:0] base(input int g);
    return 32'h3000_0000 + 32'(g) * 32'h0001_0000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [63:0] mem  [512];
    logic [63:0] pipe [3];

    wb_ram_512x64_bridge #(
      .BASE_ADDR    (32'h3000_0000 + 32'(g) * 32'h0001_0000),
      .READ_LATENCY (g + 1)
    ) u_dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_we_i  (we_i),
      .wbs_sel_i (sel_i),
      .wbs_adr_i (adr_i),
      .wbs_dat_i (dat_i),
      .wbs_ack_o (ack_w[g]),
      .wbs_dat_o (dat_w[g]),
      .ram_en_o  (en_w[g]),
      .ram_we_o  (rwe_w[g]),
      .ram_a_o   (a_w[g]),
      .ram_di_o  (di_w[g]),
      .ram_do_i  (do_w[g])
    );

    initial begin
      for (int i = 0; i < 512; i++) mem[i] = 64'd0;
      for (int i = 0; i < 3; i++) pipe[i] = 64'd0;
    end

    // RAM model: byte-write on EN, read data emerges READ_LATENCY cycles after the strobe.
    always @(posedge clk) begin
      if (en_w[g]) begin
        pipe[0] <= mem[a_w[g]];
        for (int b = 0; b < 8; b++)
          if (rwe_w[g][b]) mem[a_w[g]][8*b +: 8] <= di_w[g][8*b +: 8];
      end
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    assign do_w[g] = pipe[g];
  end

  // Monitor: every RAM strobe and every ack is matched against the expectation queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (en_w[g]) begin
          chk("strobe_expected", 64'(sq.size() > 0), 64'd1);
          if (sq.size() > 0) begin
            s_m = sq.pop_front();
            chk("strobe_dut", 64'(g), 64'(s_m.g));
            chk("strobe_cycle", 64'(cyc_cnt - s_m.t), 64'd1);
            chk("ram_a", 64'(a_w[g]), 64'(s_m.a));
            chk("ram_we", 64'(rwe_w[g]), 64'(s_m.we));
            chk("ram_di", di_w[g], s_m.di);
          end
        end
        if (ack_w[g]) begin
          chk("ack_expected", 64'(aq.size() > 0), 64'd1);
          if (aq.size() > 0) begin
            k_m = aq.pop_front();
            chk("ack_dut", 64'(g), 64'(k_m.g));
            chk("ack_cycle", 64'(cyc_cnt - k_m.t), 64'(k_m.lat));
            chk("rd_data", 64'(dat_w[g]), 64'(k_m.dat));
          end
        end
      end
    end
  end

  // One bus transaction with hand-computed RAM strobe and ack expectations.
  task automatic access(input int g, input logic [11:0] off, input logic wr, input logic [3:0] sel,
                        input logic [31:0] wd, input logic [8:0] ea, input logic [7:0] ewe,
                        input int elat, input logic [31:0] edat);
    int n;
    strobe_t s;
    ackexp_t k;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = wr; sel_i = sel;
    adr_i = base(g) + 32'(off);
    dat_i = wr ? wd : 32'd0;
    s.g = g; s.a = ea; s.we = ewe; s.di = {dat_i, dat_i}; s.t = cyc_cnt;
    sq.push_back(s);
    k.g = g; k.lat = elat; k.dat = edat; k.t = cyc_cnt;
    aq.push_back(k);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_w[g] && n < 20);
    if (!ack_w[g]) chk("ack_timeout", 64'(ack_w[g]), 64'd1);
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
  endtask

  task automatic chk_zero(input int g);
    chk("rst_ack", 64'(ack_w[g]), 64'd0);
    chk("rst_en", 64'(en_w[g]), 64'd0);
    chk("rst_we", 64'(rwe_w[g]), 64'd0);
    chk("rst_a", 64'(a_w[g]), 64'd0);
    chk("rst_di", di_w[g], 64'd0);
    chk("rst_dat", 64'(dat_w[g]), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nev;
    strobe_t s;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    sel_i = 4'h0; adr_i = 32'd0; dat_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk_zero(g);
    rst = 1'b0;

    // Instance 0, READ_LATENCY=1
    access(0, 12'h010, 1'b1, 4'hF, 32'hDEADBEEF, 9'd2,   8'h0F, 2, 32'h0);
    access(0, 12'h010, 1'b0, 4'hF, 32'h0,        9'd2,   8'h00, 3, 32'hDEADBEEF);
    access(0, 12'hFFC, 1'b1, 4'hF, 32'hAAAAAAAA, 9'd511, 8'hF0, 2, 32'hDEADBEEF);
    access(0, 12'hFFC, 1'b1, 4'h5, 32'h11223344, 9'd511, 8'h50, 2, 32'hDEADBEEF);
    access(0, 12'hFFC, 1'b0, 4'hF, 32'h0,        9'd511, 8'h00, 3, 32'hAA22AA44);
    access(0, 12'h014, 1'b1, 4'h0, 32'h12345678, 9'd2,   8'h00, 2, 32'hAA22AA44);
    access(0, 12'h014, 1'b0, 4'hF, 32'h0,        9'd2,   8'h00, 3, 32'h0);
    access(0, 12'h010, 1'b0, 4'hF, 32'h0,        9'd2,   8'h00, 3, 32'hDEADBEEF);

    // Out-of-window strobe: nothing may respond.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; sel_i = 4'hF;
    adr_i = 32'h3000_1000; dat_i = 32'h0BAD0BAD;
    nev = 0;
    repeat (10) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (en_w[g] || ack_w[g]) nev++;
    end
    chk("oow_events", 64'(nev), 64'd0);
    cyc = 1'b0; stb = 1'b0; we_i = 1'b0;

    // Instance 1, READ_LATENCY=2
    access(1, 12'h008, 1'b1, 4'hF, 32'hCAFEF00D, 9'd1, 8'h0F, 2, 32'h0);
    access(1, 12'h008, 1'b0, 4'hF, 32'h0,        9'd1, 8'h00, 4, 32'hCAFEF00D);
    access(1, 12'h00C, 1'b1, 4'hC, 32'h0BADC0DE, 9'd1, 8'hC0, 2, 32'hCAFEF00D);
    access(1, 12'h00C, 1'b0, 4'hF, 32'h0,        9'd1, 8'h00, 4, 32'h0BAD0000);

    // Instance 2, READ_LATENCY=3
    access(2, 12'h020, 1'b1, 4'hF, 32'h55AA1234, 9'd4, 8'h0F, 2, 32'h0);
    access(2, 12'h020, 1'b0, 4'hF, 32'h0,        9'd4, 8'h00, 5, 32'h55AA1234);

    // Read aborted during WAIT: strobe happens, no ack, data unchanged.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; sel_i = 4'hF;
    adr_i = base(2); dat_i = 32'd0;
    s.g = 2; s.a = 9'd0; s.we = 8'h00; s.di = 64'd0; s.t = cyc_cnt;
    sq.push_back(s);
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    nev = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_w[2]) nev++;
    end
    chk("abort_noack", 64'(nev), 64'd0);
    chk("abort_dat", 64'(dat_w[2]), 64'h55AA1234);
    access(2, 12'h000, 1'b0, 4'hF, 32'h0, 9'd0, 8'h00, 5, 32'h0);
    access(2, 12'h020, 1'b0, 4'hF, 32'h0, 9'd4, 8'h00, 5, 32'h55AA1234);

    // Reset asserted while instance 2 waits on a read.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; sel_i = 4'hF;
    adr_i = base(2); dat_i = 32'd0;
    s.g = 2; s.a = 9'd0; s.we = 8'h00; s.di = 64'd0; s.t = cyc_cnt;
    sq.push_back(s);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk_zero(g);
    rst = 1'b0;
    nev = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack_w[2]) nev++;
    end
    chk("rst_noack", 64'(nev), 64'd0);

    // Write/read pairs after reset.
    access(0, 12'h018, 1'b1, 4'hF, 32'hA5A55A5A, 9'd3, 8'h0F, 2, 32'h0);
    access(0, 12'h018, 1'b0, 4'hF, 32'h0,        9'd3, 8'h00, 3, 32'hA5A55A5A);
    access(2, 12'h020, 1'b0, 4'hF, 32'h0,        9'd4, 8'h00, 5, 32'h55AA1234);

    repeat (5) @(negedge clk);
    chk("strobe_queue_drained", 64'(sq.size()), 64'd0);
    chk("ack_queue_drained", 64'(aq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_ram_512x64_bridge.md
# wb_ram_512x64_bridge

Wishbone classic slave that sits directly upstream of the 512x64 DFFRAM macro pair and drives its single 64-bit port. It turns 32-bit bus reads and writes from the management SoC into one-cycle RAM strobes. Byte selects map onto the RAM's 8-bit byte-write enable, and the addressed 32-bit half of the 64-bit read word is returned to the bus. A small FSM sequences each access, with configurable RAM read latency.

## Interface

Parameters:
- BASE_ADDR, 32'h3000_0000: bus window base. Bits [31:12] are decoded; the window is 4 KiB.
- READ_LATENCY, 1: cycles from the RAM strobe cycle until ram_do_i is valid. Legal values are 1..3.

Ports. One clock; reset is synchronous and active-high.
- wb_clk_i  in  1  system clock; also clocks the RAM.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- ram_en_o  out  1  RAM enable (EN).
- ram_we_o  out  8  RAM byte write enables (WE).
- ram_a_o  out  9  RAM word address (A).
- ram_di_o  out  64  RAM write data (Di).
- ram_do_i  in  64  RAM read data (Do).

## Operation

- hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]).
- Address split:
  - wbs_adr_i[11:3] is the RAM word address.
  - wbs_adr_i[2] selects the half: 0 = bits [31:0], 1 = bits [63:32].
  - wbs_adr_i[1:0] are ignored.
- FSM states: IDLE, REQ, WAIT, ACK. All outputs are registered.
- IDLE, on hit: latch we, half and sel, then go to REQ. On the same edge:
  - ram_en_o <= 1.
  - ram_a_o <= adr[11:3].
  - ram_di_o <= {wbs_dat_i, wbs_dat_i}.
  - ram_we_o <= write ? (half ? {sel, 4'b0} : {4'b0, sel}) : 8'h00.
- IDLE, no hit: stay in IDLE. Out-of-window strobes are never acknowledged.
- REQ lasts one cycle; ram_en_o/ram_we_o are high only here.
  - Write: go to ACK.
  - Read: go to WAIT with the latency counter at READ_LATENCY-1.
- REQ exit: ram_en_o <= 0 and ram_we_o <= 0. ram_a_o and ram_di_o hold their values.
- WAIT: decrement the counter each cycle. When it reaches 0:
  - Capture wbs_dat_o <= half ? ram_do_i[63:32] : ram_do_i[31:0].
  - Go to ACK.
- ACK: wbs_ack_o = 1 for exactly one cycle, then go to IDLE. A new hit is accepted from IDLE on the following cycle, so accesses never run back to back without an IDLE cycle.
- wbs_dat_o holds the last read value until the next read capture. Writes do not change it.
- sel = 4'b0000 on a write: the RAM strobe is still issued with ram_we_o = 0, no byte is modified, and the write is acked normally.
- Abort: if wbs_cyc_i drops in REQ, WAIT or ACK, go to IDLE on the next edge and suppress ack.
  - A write whose REQ cycle already occurred stays committed.
  - A read abort leaves wbs_dat_o unchanged.
- Reset:
  - State goes to IDLE.
  - wbs_ack_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o and wbs_dat_o go to 0.
  - Latency counter goes to 0.
  - Reset mid-access abandons the access; if wb_rst_i coincides with the REQ cycle, the strobe still completes in that cycle.

## Timing

- Hit first sampled at edge E0: REQ is during cycle 1 and the RAM captures at E1.
- Write: wbs_ack_o high during cycle 2. Total 3 cycles from the first strobe cycle.
- Read: data is captured at the end of cycle 1+READ_LATENCY; wbs_ack_o and valid wbs_dat_o are high during cycle 2+READ_LATENCY. With READ_LATENCY=1, ack arrives in cycle 3.
- ram_en_o pulse width is exactly 1 cycle per accepted access.
- Minimum spacing between RAM strobes is 3 cycles for writes and 3+READ_LATENCY for reads.

## Test plan

- Write word 0xDEADBEEF at 0x3000_0010, sel=4'hF -> ram_a_o=9'd2, ram_we_o=8'h0F, ram_di_o=0xDEADBEEF_DEADBEEF for one cycle, ack in cycle 2. Read back the same address -> wbs_dat_o=0xDEADBEEF with ack in cycle 3 (READ_LATENCY=1).
- Upper half with partial sel: write 0x11223344 at 0x3000_0FFC, sel=4'b0101 -> ram_a_o=9'd511, ram_we_o=8'h50. Readback of a location prefilled with 0xAAAAAAAA -> 0xAA22AA44.
- Out-of-window access at 0x3000_1000 -> no ram_en_o pulse and no ack within 10 cycles.
- Abort: drop wbs_cyc_i during WAIT on a read -> no ack, state back to IDLE, wbs_dat_o unchanged. The next read completes normally.
- Latency sweep READ_LATENCY=1,2,3 -> read ack in cycle 3/4/5, and the captured data matches the RAM model.
- Reset asserted during WAIT -> the next cycle shows all outputs 0 and state IDLE. A later write/read pair works correctly.
